id_ex_hazard_reg: RTL and testbench

//  ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the single-cycle control decoder.

---
 rtl/id_ex_hazard_reg_if.sv | 43 ++++
 rtl/id_ex_hazard_reg.sv | 63 ++++++
 tb/tb_id_ex_hazard_reg.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX pipeline register bus: decoder/operand inputs from ID, registered copies for EX,
// plus the branch flush / hold controls and the stall and bubble-count status.
interface id_ex_hazard_reg_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
   logic             id_MemRead, id_MemWrite, id_Branch, id_Jump;
   logic [1:0]       id_ALUOp;
   logic [WIDTH-1:0] id_rd1, id_rd2, id_imm, id_pc4;
   logic [4:0]       id_rs, id_rt, id_rd;
   logic             flush, hold;

   logic             ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
   logic             ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
   logic [1:0]       ex_ALUOp;
   logic [WIDTH-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
   logic [4:0]       ex_rs, ex_rt, ex_rd;
   logic             ex_valid, stall;
   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
             id_MemRead, id_MemWrite, id_Branch, id_Jump,
             id_ALUOp, id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd,
             flush, hold,
      input  ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
             ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump,
             ex_ALUOp, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
             ex_valid, stall, bubble_cnt
   );

   modport slave (
      input  id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
             id_MemRead, id_MemWrite, id_Branch, id_Jump,
             id_ALUOp, id_rd1, id_rd2, id_imm, id_pc4, id_rs, id_rt, id_rd,
             flush, hold,
      output ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
             ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump,
             ex_ALUOp, ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
             ex_valid, stall, bubble_cnt
   );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush, external hold
// and a saturating count of inserted load-use bubbles.
module id_ex_hazard_reg #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input logic            clk,
   input logic            rst,
   id_ex_hazard_reg_if.slave bus
);
   localparam int PW = 10 + 4 * WIDTH + 15;

   logic [PW-1:0]    id_vec;
   logic [PW-1:0]    ex_vec;
   logic             ex_valid;
   logic [CNT_W-1:0] bubble_cnt;
   logic             lu;

   // Whole payload handled as one vector so a bubble zeroes every field alike.
   assign id_vec = {bus.id_RegDst, bus.id_ALUSrc, bus.id_MemtoReg, bus.id_RegWrite,
                    bus.id_MemRead, bus.id_MemWrite, bus.id_Branch, bus.id_Jump,
                    bus.id_ALUOp, bus.id_rd1, bus.id_rd2, bus.id_imm, bus.id_pc4,
                    bus.id_rs, bus.id_rt, bus.id_rd};

   assign {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite,
           bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch, bus.ex_Jump,
           bus.ex_ALUOp, bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_pc4,
           bus.ex_rs, bus.ex_rt, bus.ex_rd} = ex_vec;

   assign bus.ex_valid   = ex_valid;
   assign bus.bubble_cnt = bubble_cnt;

   // rt is only a source for R-type/BEQ (ALUSrc=0) and SW (MemWrite=1).
   always_comb begin
      lu = bus.ex_MemRead & ex_valid & (bus.ex_rt != '0) &
           ((bus.ex_rt == bus.id_rs) |
            ((bus.ex_rt == bus.id_rt) & (~bus.id_ALUSrc | bus.id_MemWrite)));
   end

   assign bus.stall = (lu | bus.hold) & ~bus.flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_vec     <= '0;
         ex_valid   <= 1'b0;
         bubble_cnt <= '0;
      end else if (bus.flush) begin
         ex_vec   <= '0;
         ex_valid <= 1'b0;
      end else if (bus.hold) begin
         ex_vec   <= ex_vec;
         ex_valid <= ex_valid;
      end else if (lu) begin
         ex_vec   <= '0;
         ex_valid <= 1'b0;
         if (bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end else begin
         ex_vec   <= id_vec;
         ex_valid <= 1'b1;
      end
   end
endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: directed instruction vectors push expected EX state,
// a monitor samples stall before each edge and the registered outputs after it.
module tb_id_ex_hazard_reg;
   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
   localparam int K_R = 0, K_LW = 1, K_SW = 2, K_ORI = 3;
   localparam int R_LOAD = 0, R_BUB = 1, R_KEEP = 2;

   typedef struct packed {
      logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
      logic [1:0]  ALUOp;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, rd;
   } ctl_t;

   typedef struct {
      string      name;
      ctl_t       ex;
      bit         v;
      bit         st;
      logic [3:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ex_hazard_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
   id_ex_hazard_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   ctl_t last_ex = '0;

   function automatic ctl_t get_ex();
      ctl_t c;
      c.RegDst = bus.ex_RegDst;   c.ALUSrc = bus.ex_ALUSrc;     c.MemtoReg = bus.ex_MemtoReg;
      c.RegWrite = bus.ex_RegWrite; c.MemRead = bus.ex_MemRead; c.MemWrite = bus.ex_MemWrite;
      c.Branch = bus.ex_Branch;   c.Jump = bus.ex_Jump;         c.ALUOp = bus.ex_ALUOp;
      c.rd1 = bus.ex_rd1; c.rd2 = bus.ex_rd2; c.imm = bus.ex_imm; c.pc4 = bus.ex_pc4;
      c.rs = bus.ex_rs;   c.rt = bus.ex_rt;   c.rd = bus.ex_rd;
      return c;
   endfunction

   task automatic drive(input ctl_t c, input bit fl, input bit hd);
      bus.id_RegDst = c.RegDst;   bus.id_ALUSrc = c.ALUSrc;     bus.id_MemtoReg = c.MemtoReg;
      bus.id_RegWrite = c.RegWrite; bus.id_MemRead = c.MemRead; bus.id_MemWrite = c.MemWrite;
      bus.id_Branch = c.Branch;   bus.id_Jump = c.Jump;         bus.id_ALUOp = c.ALUOp;
      bus.id_rd1 = c.rd1; bus.id_rd2 = c.rd2; bus.id_imm = c.imm; bus.id_pc4 = c.pc4;
      bus.id_rs = c.rs;   bus.id_rt = c.rt;   bus.id_rd = c.rd;
      bus.flush = fl;     bus.hold = hd;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, want);
      end
   endtask

   task automatic chk_ex(input string nm, input ctl_t got, input ctl_t want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, got, want);
      end
   endtask

   function automatic ctl_t ins(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
      ctl_t c = '0;
      c.rs = rs; c.rt = rt; c.rd = rd;
      c.rd1 = $urandom; c.rd2 = $urandom; c.imm = $urandom; c.pc4 = $urandom;
      case (kind)
         K_R:     begin c.RegDst = 1'b1; c.RegWrite = 1'b1; c.ALUOp = 2'b10; end
         K_LW:    begin c.ALUSrc = 1'b1; c.MemtoReg = 1'b1; c.RegWrite = 1'b1; c.MemRead = 1'b1; end
         K_SW:    begin c.ALUSrc = 1'b1; c.MemWrite = 1'b1; end
         default: begin c.ALUSrc = 1'b1; c.RegWrite = 1'b1; c.ALUOp = 2'b11; end
      endcase
      return c;
   endfunction

   // One vector per cycle: present ID inputs at the falling edge, queue the expected outcome.
   task automatic apply(input string nm, input ctl_t c, input bit fl, input bit hd, input int res,
                        input bit ev, input bit st, input logic [3:0] cnt);
      exp_t e;
      @(negedge clk);
      drive(c, fl, hd);
      if (res == R_LOAD) last_ex = c;
      else if (res == R_BUB) last_ex = '0;
      e.name = nm; e.ex = last_ex; e.v = ev; e.st = st; e.cnt = cnt;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".stall"}, 32'(bus.stall), 32'(e.st));
            @(posedge clk);
            #1;
            chk_ex({e.name, ".ex"}, get_ex(), e.ex);
            chk({e.name, ".valid"}, 32'(bus.ex_valid), 32'(e.v));
            chk({e.name, ".cnt"}, 32'(bus.bubble_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin : watchdog
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [159:0] rnd;
      ctl_t a, b;
      int c;
      rst = 1'b0;
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      drive(rnd[$bits(ctl_t)-1:0], 1'b0, 1'b0);
      #3;
      chk_ex("rst.ex", get_ex(), '0);
      chk("rst.valid", 32'(bus.ex_valid), 0);
      chk("rst.stall", 32'(bus.stall), 0);
      chk("rst.cnt", 32'(bus.bubble_cnt), 0);
      @(posedge clk);
      #1;
      chk_ex("rst_edge.ex", get_ex(), '0);
      chk("rst_edge.valid", 32'(bus.ex_valid), 0);
      rst = 1'b1;

      apply("rtype", ins(K_R, 5'd1, 5'd2, 5'd3), 0, 0, R_LOAD, 1, 0, 4'd0);
      apply("lw8", ins(K_LW, 5'd1, 5'd8, 5'd0), 0, 0, R_LOAD, 1, 0, 4'd0);
      a = ins(K_R, 5'd8, 5'd9, 5'd10);
      apply("lu_rs", a, 0, 0, R_BUB, 0, 1, 4'd1);
      apply("lu_replay", a, 0, 0, R_LOAD, 1, 0, 4'd1);
      apply("lw8b", ins(K_LW, 5'd2, 5'd8, 5'd0), 0, 0, R_LOAD, 1, 0, 4'd1);
      apply("ori_rt", ins(K_ORI, 5'd3, 5'd8, 5'd0), 0, 0, R_LOAD, 1, 0, 4'd1);
      apply("lw0", ins(K_LW, 5'd0, 5'd0, 5'd0), 0, 0, R_LOAD, 1, 0, 4'd1);
      apply("r_zero", ins(K_R, 5'd0, 5'd0, 5'd4), 0, 0, R_LOAD, 1, 0, 4'd1);
      apply("lw5", ins(K_LW, 5'd1, 5'd5, 5'd0), 0, 0, R_LOAD, 1, 0, 4'd1);
      b = ins(K_SW, 5'd6, 5'd5, 5'd0);
      apply("sw_rt", b, 0, 0, R_BUB, 0, 1, 4'd2);
      apply("sw_replay", b, 0, 0, R_LOAD, 1, 0, 4'd2);
      apply("lw7", ins(K_LW, 5'd1, 5'd7, 5'd0), 0, 0, R_LOAD, 1, 0, 4'd2);
      apply("flush_prio", ins(K_R, 5'd7, 5'd2, 5'd3), 1, 1, R_BUB, 0, 0, 4'd2);
      apply("pre_hold", ins(K_R, 5'd1, 5'd2, 5'd3), 0, 0, R_LOAD, 1, 0, 4'd2);
      a = ins(K_LW, 5'd4, 5'd9, 5'd0);
      for (int i = 0; i < 3; i++)
         apply("hold", a, 0, 1, R_KEEP, 1, 1, 4'd2);
      apply("hold_rel", a, 0, 0, R_LOAD, 1, 0, 4'd2);

      c = 2;
      for (int i = 0; i < 15; i++) begin
         apply("sat_lw", ins(K_LW, 5'd1, 5'd8, 5'd0), 0, 0, R_LOAD, 1, 0, 4'(c));
         c = (c == 15) ? 15 : c + 1;
         apply("sat_lu", ins(K_R, 5'd8, 5'd2, 5'd3), 0, 0, R_BUB, 0, 1, 4'(c));
      end
      apply("pre_arst", ins(K_LW, 5'd1, 5'd8, 5'd0), 0, 0, R_LOAD, 1, 0, 4'd15);

      @(negedge clk);
      drive(ins(K_R, 5'd8, 5'd2, 5'd3), 1'b0, 1'b0);
      #2;
      chk("arst.stall_before", 32'(bus.stall), 1);
      chk("arst.cnt_before", 32'(bus.bubble_cnt), 15);
      #1 rst = 1'b0;
      #1;
      chk("arst.stall", 32'(bus.stall), 0);
      chk("arst.valid", 32'(bus.ex_valid), 0);
      chk("arst.cnt", 32'(bus.bubble_cnt), 0);
      chk_ex("arst.ex", get_ex(), '0);
      @(posedge clk);
      #1 rst = 1'b1;
      apply("post_arst", ins(K_R, 5'd8, 5'd2, 5'd3), 0, 0, R_LOAD, 1, 0, 4'd0);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
